// File: rtl/rf_write_bank_if.sv
// Write-port bus of the 8 x WIDTH register file: write request in, register
// contents and per-register status out.
interface rf_write_bank_if #(parameter int WIDTH = 16);
    logic             clr;
    logic             wr_en;
    logic [2:0]       wr_sel;
    logic [WIDTH-1:0] wr_data;
    logic [WIDTH-1:0] r0_out;
    logic [WIDTH-1:0] r1_out;
    logic [WIDTH-1:0] r2_out;
    logic [WIDTH-1:0] r3_out;
    logic [WIDTH-1:0] r4_out;
    logic [WIDTH-1:0] r5_out;
    logic [WIDTH-1:0] r6_out;
    logic [WIDTH-1:0] r7_out;
    logic [7:0]       written;
    logic [7:0]       wr_onehot;

    modport master (
        output clr, wr_en, wr_sel, wr_data,
        input  r0_out, r1_out, r2_out, r3_out, r4_out, r5_out, r6_out, r7_out,
        input  written, wr_onehot
    );

    modport slave (
        input  clr, wr_en, wr_sel, wr_data,
        output r0_out, r1_out, r2_out, r3_out, r4_out, r5_out, r6_out, r7_out,
        output written, wr_onehot
    );
endinterface

// File: rtl/rf_write_bank.sv
// Write side of the 8-entry register file: one-hot write decode, register
// storage, per-register written flags and a registered copy of the decode.
module rf_write_bank #(
    parameter int               WIDTH     = 16,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input logic            clk,
    input logic            rst,
    rf_write_bank_if.slave bus
);

    logic [WIDTH-1:0] regs [8];
    logic [7:0]       en;
    logic [7:0]       written;
    logic [7:0]       wr_onehot;

    // Gating with wr_en first keeps an unknown wr_sel from reaching state while idle.
    always_comb begin
        en = 8'h00;
        if (bus.wr_en) begin
            for (int i = 0; i < 8; i++) begin
                en[i] = (bus.wr_sel == 3'(i));
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst || bus.clr) begin
            for (int i = 0; i < 8; i++) begin
                regs[i] <= RESET_VAL;
            end
            written   <= 8'h00;
            wr_onehot <= 8'h00;
        end else begin
            wr_onehot <= en;
            for (int i = 0; i < 8; i++) begin
                if (en[i]) begin
                    regs[i]    <= bus.wr_data;
                    written[i] <= 1'b1;
                end
            end
        end
    end

    assign bus.r0_out    = regs[0];
    assign bus.r1_out    = regs[1];
    assign bus.r2_out    = regs[2];
    assign bus.r3_out    = regs[3];
    assign bus.r4_out    = regs[4];
    assign bus.r5_out    = regs[5];
    assign bus.r6_out    = regs[6];
    assign bus.r7_out    = regs[7];
    assign bus.written   = written;
    assign bus.wr_onehot = wr_onehot;

endmodule

// File: doc/rf_write_bank.md
# rf_write_bank

Write side of the 8-entry × 16-bit general-purpose register file. Decodes a 3-bit write select into one-hot enables and stores write data into one of eight 16-bit registers. Presents all eight register values in parallel to the read-side 8:1 selection muxes. Tracks a per-register written flag so that decode logic can detect reads of never-written registers.

## Interface

Parameters:
- WIDTH, 16, data width of each register
- RESET_VAL, 16'h0000, value loaded into every register on reset or clear

Ports:
- clk  input  1  system clock; all state updates on the rising edge
- rst  input  1  synchronous, active-high reset
- clr  input  1  synchronous clear of all registers and written flags
- wr_en  input  1  write strobe
- wr_sel  input  3  destination register index, 0–7
- wr_data  input  WIDTH  data to write
- r0_out … r7_out  output  WIDTH each  current contents of registers 0–7
- written  output  8  bit i = 1 once register i has been written since the last reset or clear
- wr_onehot  output  8  registered copy of the decoded enable from the last cycle, for debug and trace; all zeros if no write occurred

## Operation

- Decode: the enable vector en[i] = wr_en & (wr_sel == i). It is purely combinational inside the block and one-hot or zero.
- On each rising clk edge, rules apply in the following priority order:
  - **rst = 1:** every rN_out = RESET_VAL; written = 8'h00; wr_onehot = 8'h00.
  - **rst = 0, clr = 1:** same effect as reset. A concurrent wr_en is dropped, so no register takes wr_data.
  - **Otherwise, wr_en = 1:**
    - register[wr_sel] ← wr_data;
    - written[wr_sel] ← 1;
    - wr_onehot ← en;
    - all other registers and flags hold.
  - **Otherwise, wr_en = 0:** all registers and written hold; wr_onehot ← 8'h00.
- There is exactly one write port, so write collisions cannot occur.
- wr_sel is ignored when wr_en = 0. X on wr_sel with wr_en = 0 must not corrupt state.
- Writing a register that is already written overwrites its data; its flag stays 1.
- Back-to-back writes to the same index on consecutive cycles: the last write wins and each is visible one cycle after its edge.
- Full-width data, including 16'hFFFF and 16'h8000, is stored unmodified. There is no sign extension or truncation.

## Timing

- Write latency is one cycle. Data presented with wr_en at edge N appears on rN_out immediately after edge N.
- There is no internal write-to-read bypass. A read mux sampling rN_out in the same cycle as the write sees the old value. Forwarding is handled by the pipeline's forwarding unit.
- All outputs are driven directly from flops, with no combinational path from inputs to outputs.
- Reset mid-stream: a write asserted in the same cycle as rst is discarded. Outputs are RESET_VAL starting from the next cycle.
- clr has the same timing as rst and can be asserted for a single cycle.

## Test plan

- **Reset:** assert rst for 2 cycles with wr_en = 1, wr_sel = 3, wr_data = 16'hBEEF → all rN_out = 16'h0000, written = 8'h00, wr_onehot = 8'h00.
- **Walking write:** write 16'h1110 + i to each index i = 0…7 on consecutive cycles → after each edge only r_i changes; written fills 01, 03, 07, …, FF; wr_onehot = 1 << i for each cycle.
- **Overwrite and hold:**
  - write r5 = 16'hFFFF, then r5 = 16'h8000, then idle 3 cycles → r5_out = 16'h8000 and holds;
  - written[5] stays 1;
  - wr_onehot returns to 00 after the last write;
  - other registers are unchanged.
- **Same-cycle read:** with r2 = 16'h0001, write r2 = 16'h0002 → in the write cycle r2_out = 16'h0001; in the next cycle r2_out = 16'h0002.
- **Clear vs. write:** from a full file, assert clr with wr_en = 1, wr_sel = 7, wr_data = 16'hAAAA → all registers = 16'h0000, written = 00, r7_out ≠ 16'hAAAA.
- **Idle X immunity:** wr_en = 0 with wr_sel = 3'bxxx and wr_data = 16'hxxxx for 4 cycles → no register or flag changes; wr_onehot = 00.
